// File: rtl/sensor_frame_controller.sv
// Frame scheduler and slot-position decoder for the 16-slot time-encoded sensor bus.
// Issues sample_en, decodes each pulse position into (address, value), and commits
// a coherent per-frame result bank at the end of every frame.
module sensor_frame_controller #(
  parameter int unsigned GAP = 1024
) (
  input  logic        clk_division,
  input  logic        rst,
  input  logic        start,
  input  logic        auto_en,
  input  logic        slot_in,
  output logic        sample_en,
  output logic        busy,
  output logic        frame_done,
  input  logic [3:0]  rd_addr,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  output logic [15:0] valid_mask,
  output logic [15:0] dup_err
);

  localparam int unsigned N_SLOT = 16;
  localparam int unsigned K_W    = 12;
  localparam int unsigned VAL_W  = 8;
  localparam int unsigned GAP_W  = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [K_W-1:0]   K_LAST   = K_W'(4095);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_CAPTURE,
    ST_DONE,
    ST_WAIT
  } state_t;

  state_t state_q, state_d;

  logic [K_W-1:0]   k_q, k_d;
  logic [GAP_W-1:0] gap_q, gap_d;

  logic [N_SLOT-1:0][VAL_W-1:0] shadow_val_q, shadow_val_d;
  logic [N_SLOT-1:0]            shadow_mask_q, shadow_mask_d;
  logic [N_SLOT-1:0]            shadow_err_q, shadow_err_d;

  logic [N_SLOT-1:0][VAL_W-1:0] bank_val_q, bank_val_d;
  logic [N_SLOT-1:0]            bank_mask_q, bank_mask_d;
  logic [N_SLOT-1:0]            bank_err_q, bank_err_d;

  logic sample_en_q, sample_en_d;
  logic busy_q, busy_d;
  logic frame_done_q, frame_done_d;

  logic [3:0] slot_a;

  // Next-state, frame counter, shadow capture and bank commit.
  always_comb begin
    state_d       = state_q;
    k_d           = k_q;
    gap_d         = gap_q;
    shadow_val_d  = shadow_val_q;
    shadow_mask_d = shadow_mask_q;
    shadow_err_d  = shadow_err_q;
    bank_val_d    = bank_val_q;
    bank_mask_d   = bank_mask_q;
    bank_err_d    = bank_err_q;
    slot_a        = k_q[3:0];

    case (state_q)
      ST_IDLE: begin
        if (start || auto_en) begin
          state_d = ST_ARM;
        end
      end
      ST_ARM: begin
        shadow_mask_d = '0;
        shadow_err_d  = '0;
        k_d           = '0;
        state_d       = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        // First pulse per address wins; later pulses only flag a duplicate.
        if (slot_in) begin
          if (!shadow_mask_q[slot_a]) begin
            shadow_val_d[slot_a]  = k_q[11:4];
            shadow_mask_d[slot_a] = 1'b1;
          end else begin
            shadow_err_d[slot_a] = 1'b1;
          end
        end
        if (k_q == K_LAST) begin
          state_d = ST_DONE;
        end else begin
          k_d = k_q + K_W'(1);
        end
      end
      ST_DONE: begin
        bank_val_d  = shadow_val_q;
        bank_mask_d = shadow_mask_q;
        bank_err_d  = shadow_err_q;
        if (auto_en) begin
          state_d = ST_WAIT;
          gap_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (!auto_en) begin
          state_d = ST_IDLE;
        end else if (gap_q == GAP_LAST) begin
          state_d = ST_ARM;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    sample_en_d  = (state_d == ST_ARM);
    busy_d       = (state_d != ST_IDLE);
    frame_done_d = (state_d == ST_DONE);
  end

  // State, counters, shadow and committed bank registers.
  always_ff @(posedge clk_division) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      k_q           <= '0;
      gap_q         <= '0;
      shadow_val_q  <= '0;
      shadow_mask_q <= '0;
      shadow_err_q  <= '0;
      bank_val_q    <= '0;
      bank_mask_q   <= '0;
      bank_err_q    <= '0;
      sample_en_q   <= 1'b0;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      k_q           <= k_d;
      gap_q         <= gap_d;
      shadow_val_q  <= shadow_val_d;
      shadow_mask_q <= shadow_mask_d;
      shadow_err_q  <= shadow_err_d;
      bank_val_q    <= bank_val_d;
      bank_mask_q   <= bank_mask_d;
      bank_err_q    <= bank_err_d;
      sample_en_q   <= sample_en_d;
      busy_q        <= busy_d;
      frame_done_q  <= frame_done_d;
    end
  end

  assign sample_en  = sample_en_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign valid_mask = bank_mask_q;
  assign dup_err    = bank_err_q;
  assign rd_data    = bank_val_q[rd_addr];
  assign rd_valid   = bank_mask_q[rd_addr];

endmodule
